// File: rtl/interval_meter_if.sv
// Start/stop marker inputs and measurement results of interval_meter.
// The block itself connects through the slave modport.
interface interval_meter_if #(
    parameter int W = 8
);
    logic         start_in;
    logic         stop_in;
    logic [W-1:0] interval;
    logic         valid;
    logic         timeout;
    logic         busy;

    modport master (
        output start_in,
        output stop_in,
        input  interval,
        input  valid,
        input  timeout,
        input  busy
    );

    modport slave (
        input  start_in,
        input  stop_in,
        output interval,
        output valid,
        output timeout,
        output busy
    );
endinterface

// File: rtl/interval_meter.sv
// Measures the distance in clk cycles between a start marker and the next stop marker.
// Markers may come from another clock domain, so they can be synchronized first.
module interval_meter #(
    parameter int W       = 8,
    parameter int SYNC    = 1,
    parameter int RESTART = 0
) (
    input logic            clk,
    input logic            reset_n,
    interval_meter_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [W-1:0] ONE_C      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ALL_ONES_C = {W{1'b1}};
    localparam bit           RESTART_EN = (RESTART != 0);

    logic start_lvl_s;
    logic stop_lvl_s;

    generate
        if (SYNC != 0) begin : g_sync
            logic start_meta_r;
            logic start_sync_r;
            logic stop_meta_r;
            logic stop_sync_r;

            // Two-flop synchronizers for both markers.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    start_meta_r <= 1'b0;
                    start_sync_r <= 1'b0;
                    stop_meta_r  <= 1'b0;
                    stop_sync_r  <= 1'b0;
                end else begin
                    start_meta_r <= bus.start_in;
                    start_sync_r <= start_meta_r;
                    stop_meta_r  <= bus.stop_in;
                    stop_sync_r  <= stop_meta_r;
                end
            end

            assign start_lvl_s = start_sync_r;
            assign stop_lvl_s  = stop_sync_r;
        end else begin : g_direct
            assign start_lvl_s = bus.start_in;
            assign stop_lvl_s  = bus.stop_in;
        end
    endgenerate

    state_t       state_r, state_s;
    logic [W-1:0] count_r, count_s;
    logic [W-1:0] interval_r, interval_s;
    logic         valid_r, valid_s;
    logic         timeout_r, timeout_s;
    logic         busy_r, busy_s;
    logic         start_prev_r;
    logic         stop_prev_r;
    logic         start_evt_s;
    logic         stop_evt_s;

    assign start_evt_s = start_lvl_s & ~start_prev_r;
    assign stop_evt_s  = stop_lvl_s & ~stop_prev_r;

    // State, elapsed count, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            count_r      <= {W{1'b0}};
            interval_r   <= {W{1'b0}};
            valid_r      <= 1'b0;
            timeout_r    <= 1'b0;
            busy_r       <= 1'b0;
            start_prev_r <= 1'b0;
            stop_prev_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            interval_r   <= interval_s;
            valid_r      <= valid_s;
            timeout_r    <= timeout_s;
            busy_r       <= busy_s;
            start_prev_r <= start_lvl_s;
            stop_prev_r  <= stop_lvl_s;
        end
    end

    // count_r holds the cycles elapsed since the start event; all-ones is terminal.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        interval_s = interval_r;
        valid_s    = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_evt_s) begin
                    state_s = ST_COUNT;
                    count_s = ONE_C;
                end else begin
                    count_s = count_r;
                end
            end
            ST_COUNT: begin
                if (stop_evt_s) begin
                    interval_s = count_r;
                    valid_s    = 1'b1;
                    state_s    = ST_IDLE;
                end else if (start_evt_s && RESTART_EN) begin
                    count_s = ONE_C;
                end else if (count_r == ALL_ONES_C) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    count_s = count_r + ONE_C;
                end
            end
            default: begin
                state_s = ST_IDLE;
                count_s = {W{1'b0}};
            end
        endcase
        busy_s = (state_s == ST_COUNT);
    end

    assign bus.interval = interval_r;
    assign bus.valid    = valid_r;
    assign bus.timeout  = timeout_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_interval_meter.sv
// Self-checking bench: two interval_meter variants driven by the same pins, checked
// by a scoreboard fed from a timestamp-based reference model.
module tb_interval_meter;
    localparam int W    = 8;
    localparam int MAXC = 255;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic start_pin = 1'b0;
    logic stop_pin  = 1'b0;

    always #5 clk = ~clk;

    interval_meter_if #(.W(W)) bus0 ();
    interval_meter_if #(.W(W)) bus1 ();

    assign bus0.start_in = start_pin;
    assign bus0.stop_in  = stop_pin;
    assign bus1.start_in = start_pin;
    assign bus1.stop_in  = stop_pin;

    interval_meter #(.W(W), .SYNC(1), .RESTART(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    interval_meter #(.W(W), .SYNC(0), .RESTART(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    typedef struct {
        bit is_to;
        int iv;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    bit   meas[2];
    int   t0[2];
    int   m_int[2];
    int   ecount   = 0;
    bit   sh[$];
    bit   ph[$];
    int   vcnt[2];
    int   tcnt[2];
    int   vcyc[2];
    int   bcnt[2];
    int   ncyc     = 0;
    bit   done     = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input bit to, input int iv);
        exp_t e;
        e.is_to = to;
        e.iv    = iv;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference model: events are pin rising edges delayed by the synchronizer depth;
    // a measurement is the edge-count distance between accepted start and stop.
    always @(posedge clk) begin
        int d;
        bit st, sp, rs;
        if (!reset_n) begin
            sh = '{1'b0, 1'b0, 1'b0, 1'b0};
            ph = '{1'b0, 1'b0, 1'b0, 1'b0};
            for (int k = 0; k < 2; k++) begin
                meas[k]  = 1'b0;
                m_int[k] = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            sh.push_front(start_pin);
            void'(sh.pop_back());
            ph.push_front(stop_pin);
            void'(ph.pop_back());
            for (int k = 0; k < 2; k++) begin
                d  = (k == 0) ? 2 : 0;
                rs = (k == 1);
                st = sh[d] && !sh[d+1];
                sp = ph[d] && !ph[d+1];
                if (!meas[k]) begin
                    if (st) begin
                        meas[k] = 1'b1;
                        t0[k]   = ecount;
                    end
                end else if (sp) begin
                    m_int[k] = ecount - t0[k];
                    push_exp(k, 1'b0, m_int[k]);
                    meas[k] = 1'b0;
                end else if (st && rs) begin
                    t0[k] = ecount;
                end else if (ecount - t0[k] >= MAXC) begin
                    push_exp(k, 1'b1, m_int[k]);
                    meas[k] = 1'b0;
                end
            end
        end
        ecount++;
    end

    task automatic mon(input int k, input bit v, input bit to, input bit b, input int iv);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : q1.size();
        if (b) bcnt[k]++;
        if (v || to) begin
            if (v) begin
                vcnt[k]++;
                vcyc[k] = ncyc;
            end
            if (to) tcnt[k]++;
            if (n == 0) begin
                check($sformatf("d%0d_unexpected_pulse", k), int'(v) + int'(to), 0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("d%0d_pulse_kind", k), {30'd0, v, to}, e.is_to ? 1 : 2);
                check($sformatf("d%0d_pulse_interval", k), iv, e.iv);
            end
        end else if (n != 0) begin
            check($sformatf("d%0d_missing_pulse", k), n, 0);
            if (k == 0) q0.delete();
            else        q1.delete();
        end
        check($sformatf("d%0d_busy", k), int'(b), int'(meas[k]));
        check($sformatf("d%0d_interval_held", k), iv, m_int[k]);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        ncyc++;
        mon(0, bus0.valid, bus0.timeout, bus0.busy, int'(bus0.interval));
        mon(1, bus1.valid, bus1.timeout, bus1.busy, int'(bus1.interval));
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL watchdog actual=timeout expected=finish");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        int r, tc0, tc1, vc0, vc1, bc0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(4);
        check("reset_interval_d0", int'(bus0.interval), 0);
        check("reset_busy_d0", int'(bus0.busy), 0);
        check("reset_valid_d0", int'(bus0.valid), 0);

        // Start then stop 10 cycles later; compare SYNC=1 and SYNC=0 timing.
        bc0 = bcnt[0];
        start_pin = 1'b1; tick(1); start_pin = 1'b0; tick(9);
        stop_pin  = 1'b1; tick(1); stop_pin  = 1'b0; tick(20);
        check("s10_interval_d0", int'(bus0.interval), 10);
        check("s10_interval_d1", int'(bus1.interval), 10);
        check("s10_busy_cycles_d0", bcnt[0] - bc0, 10);
        check("s10_valid_lag", vcyc[0] - vcyc[1], 2);

        // Start with no stop: timeout, interval held.
        tc0 = tcnt[0]; tc1 = tcnt[1];
        start_pin = 1'b1; tick(1); start_pin = 1'b0; tick(300);
        check("to_count_d0", tcnt[0] - tc0, 1);
        check("to_count_d1", tcnt[1] - tc1, 1);
        check("to_interval_d0", int'(bus0.interval), 10);
        check("to_busy_d0", int'(bus0.busy), 0);

        // Stop at the last countable cycle.
        tc0 = tcnt[0];
        start_pin = 1'b1; tick(1); start_pin = 1'b0; tick(254);
        stop_pin  = 1'b1; tick(1); stop_pin  = 1'b0; tick(10);
        check("max_interval_d0", int'(bus0.interval), 255);
        check("max_interval_d1", int'(bus1.interval), 255);
        check("max_no_timeout_d0", tcnt[0] - tc0, 0);

        // Stop one cycle after start.
        start_pin = 1'b1; tick(1); start_pin = 1'b0;
        stop_pin  = 1'b1; tick(1); stop_pin  = 1'b0; tick(10);
        check("min_interval_d0", int'(bus0.interval), 1);
        check("min_interval_d1", int'(bus1.interval), 1);

        // Second start at +5, stop at +12: ignored vs restart.
        start_pin = 1'b1; tick(1); start_pin = 1'b0; tick(4);
        start_pin = 1'b1; tick(1); start_pin = 1'b0; tick(6);
        stop_pin  = 1'b1; tick(1); stop_pin  = 1'b0; tick(10);
        check("restart0_interval_d0", int'(bus0.interval), 12);
        check("restart1_interval_d1", int'(bus1.interval), 7);

        // Reset mid-measurement, then a stop.
        vc0 = vcnt[0]; vc1 = vcnt[1]; tc0 = tcnt[0];
        start_pin = 1'b1; tick(1); start_pin = 1'b0; tick(3);
        reset_n   = 1'b0; tick(1); reset_n   = 1'b1; tick(3);
        stop_pin  = 1'b1; tick(1); stop_pin  = 1'b0; tick(10);
        check("rst_interval_d0", int'(bus0.interval), 0);
        check("rst_interval_d1", int'(bus1.interval), 0);
        check("rst_busy_d0", int'(bus0.busy), 0);
        check("rst_no_valid_d0", vcnt[0] - vc0, 0);
        check("rst_no_valid_d1", vcnt[1] - vc1, 0);
        check("rst_no_timeout_d0", tcnt[0] - tc0, 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                start_pin = 1'b1; tick($urandom_range(1, 3)); start_pin = 1'b0;
            end else if (r < 80) begin
                stop_pin = 1'b1; tick($urandom_range(1, 3)); stop_pin = 1'b0;
            end else if (r < 84) begin
                start_pin = ($urandom_range(0, 1) == 1);
                reset_n = 1'b0; tick(1); reset_n = 1'b1;
                tick(4); start_pin = 1'b0;
            end else if (r < 87) begin
                tick($urandom_range(250, 300));
            end else begin
                start_pin = 1'b1; stop_pin = 1'b1;
                tick($urandom_range(1, 2));
                start_pin = 1'b0; stop_pin = 1'b0;
            end
            tick($urandom_range(0, 12));
        end

        tick(300);
        check("final_queue_d0", q0.size(), 0);
        check("final_queue_d1", q1.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interval_meter.md
INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001 Parameter W, default 8: interval counter and result width in bits; W SHALL be at least 2.
REQ-002 Parameter SYNC, default 1: when 1, start_in and stop_in SHALL each pass through a two-flop posedge synchronizer; when 0, they SHALL be used directly.
REQ-003 Parameter RESTART, default 0: when 1, a start event during measurement SHALL restart it; when 0, it SHALL be ignored.
REQ-004 clk  input  1  sole clock; all flops SHALL update on its rising edge.
REQ-005 reset_n  input  1  synchronous reset, active-low.
REQ-006 start_in  input  1  start marker, possibly from another clock domain.
REQ-007 stop_in  input  1  stop marker, possibly from another clock domain.
REQ-008 interval  output  W  last measured start-to-stop distance in clk cycles; held between measurements.
REQ-009 valid  output  1  one-cycle pulse: interval has just been updated.
REQ-010 timeout  output  1  one-cycle pulse: measurement abandoned with no stop.
REQ-011 busy  output  1  high while a measurement is in progress.

Function
REQ-012 Event definition: a start (stop) event SHALL be a cycle in which the post-synchronizer signal is 1 and its registered copy from the previous cycle is 0 (rising edge only).
REQ-013 Both inputs SHALL have identical pipeline depth, so the measured interval SHALL NOT depend on SYNC.
REQ-014 States: IDLE and COUNT only; busy SHALL be 1 exactly in COUNT.
REQ-015 IDLE: a start event in cycle T SHALL enter COUNT in cycle T+1 with an elapsed count of 0 at cycle T.
REQ-016 IDLE: a stop event SHALL be ignored with no output change, including a stop coinciding with the accepted start.
REQ-017 COUNT: a stop event in cycle T+N, with 1 <= N <= 2^W-1, SHALL produce interval=N and valid=1 in cycle T+N+1, and SHALL return to IDLE in cycle T+N+1.
REQ-018 COUNT: if no stop event occurs by cycle T+2^W-1, the block SHALL assert timeout=1 in cycle T+2^W, return to IDLE, and leave interval unchanged.
REQ-019 Boundary at N=2^W-1: if the stop event falls in cycle T+2^W-1, the block SHALL report valid with interval all-ones and SHALL NOT assert timeout.
REQ-020 The counter SHALL never wrap; the all-ones count SHALL be terminal.
REQ-021 Start during COUNT with RESTART=1: the block SHALL restart so that T equals the new event cycle.
REQ-022 Start during COUNT with RESTART=0: the event SHALL be ignored.
REQ-023 Simultaneous start and stop in COUNT: the stop SHALL complete the current measurement; the start SHALL be ignored regardless of RESTART.
REQ-024 A start event in the cycle in which valid or timeout is asserted SHALL be accepted as a new measurement.
REQ-025 valid and timeout SHALL be registered outputs, mutually exclusive, and each high for exactly one cycle per occurrence.

Reset
REQ-026 While reset_n=0 at a rising clk edge, the block SHALL load: state=IDLE, interval=0, valid=0, timeout=0, busy=0, all synchronizer and edge-history flops=0.
REQ-027 Reset SHALL abort an in-progress measurement with no valid or timeout pulse.
REQ-028 An input held high across reset release SHALL produce one start (or stop) event once the synchronizer fills; this behaviour is intentional.
REQ-029 No output SHALL change asynchronously to clk.

Verification (W=8, SYNC=1, RESTART=0 unless stated)
REQ-030 Start pulse, then a stop pulse 10 cycles later -> one valid pulse, interval=10, busy high for exactly 10 cycles.
REQ-031 Start, then no stop -> timeout pulse 256 cycles after the start event, interval keeps its previous value, busy returns to 0.
REQ-032 Stop exactly 255 cycles after start -> valid, interval=8'hFF, no timeout. Stop exactly 1 cycle after start -> interval=1.
REQ-033 Start at 0, second start at +5, stop at +12:
- RESTART=0 -> interval=12.
- RESTART=1 -> interval=7.
REQ-034 reset_n low for 1 cycle mid-measurement (+4) followed by a stop -> no valid, no timeout, busy=0, interval=0.
REQ-035 Repeat scenario REQ-030 with SYNC=0 -> interval=10, with valid occurring 2 cycles earlier relative to the input pins.
